// File: rtl/tagged_register_file.sv
// Architectural register file with per-register busy bit and producer tag.
// Issue marks a destination busy under a tag. A commit with a matching tag retires the value.
module tagged_register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int TAG_W = 4,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [NREAD*AW-1:0]    rs_in,
  output logic [NREAD*XLEN-1:0]  rd_out,
  output logic [NREAD-1:0]       rbusy_out,
  output logic [NREAD*TAG_W-1:0] rtag_out,
  input  logic                   issue_valid_in,
  input  logic [AW-1:0]          issue_addr_in,
  input  logic [TAG_W-1:0]       issue_tag_in,
  input  logic                   commit_valid_in,
  input  logic [AW-1:0]          commit_addr_in,
  input  logic [TAG_W-1:0]       commit_tag_in,
  input  logic [XLEN-1:0]        commit_data_in,
  input  logic                   flush_in,
  output logic [CW-1:0]          busy_count_out
);

  logic [XLEN-1:0]  value_q [NREGS];
  logic [XLEN-1:0]  value_d [NREGS];
  logic [TAG_W-1:0] tag_q   [NREGS];
  logic [TAG_W-1:0] tag_d   [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic issue_en_s;
  logic commit_en_s;
  logic issue_set_s;
  logic commit_clear_s;

  // Qualify issue/commit: register 0 and out-of-range addresses are inert.
  always_comb begin
    issue_en_s     = issue_valid_in && (issue_addr_in != '0) && !flush_in
                     && (int'(issue_addr_in) < NREGS);
    commit_en_s    = commit_valid_in && (commit_addr_in != '0)
                     && (int'(commit_addr_in) < NREGS);
    issue_set_s    = 1'b0;
    commit_clear_s = 1'b0;
    if (issue_en_s) begin
      issue_set_s = !busy_q[issue_addr_in];
    end else begin
      issue_set_s = 1'b0;
    end
    // A same-cycle issue to the committed register keeps it busy under the new tag.
    if (commit_en_s) begin
      commit_clear_s = busy_q[commit_addr_in]
                       && (tag_q[commit_addr_in] == commit_tag_in)
                       && !(issue_en_s && (issue_addr_in == commit_addr_in));
    end else begin
      commit_clear_s = 1'b0;
    end
  end

  // Next-state computation for values, busy bits, tags and busy count.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    count_d = count_q;
    if (commit_en_s) begin
      value_d[commit_addr_in] = commit_data_in;
    end else begin
      value_d = value_q;
    end
    if (flush_in) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (commit_clear_s) begin
        busy_d[commit_addr_in] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (issue_en_s) begin
        busy_d[issue_addr_in] = 1'b1;
        tag_d[issue_addr_in]  = issue_tag_in;
      end else begin
        tag_d = tag_q;
      end
      count_d = count_q + CW'(issue_set_s) - CW'(commit_clear_s);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NREGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count_out = count_q;

  // Combinational read ports with commit-address bypass.
  always_comb begin
    rd_out    = '0;
    rbusy_out = '0;
    rtag_out  = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0] rs;
      rs = rs_in[k*AW +: AW];
      if ((rs != '0) && (int'(rs) < NREGS)) begin
        rtag_out[k*TAG_W +: TAG_W] = tag_q[rs];
        if (commit_en_s && (commit_addr_in == rs)) begin
          rd_out[k*XLEN +: XLEN] = commit_data_in;
          rbusy_out[k]           = busy_q[rs] && (tag_q[rs] != commit_tag_in);
        end else begin
          rd_out[k*XLEN +: XLEN] = value_q[rs];
          rbusy_out[k]           = busy_q[rs];
        end
      end else begin
        rd_out[k*XLEN +: XLEN]     = '0;
        rbusy_out[k]               = 1'b0;
        rtag_out[k*TAG_W +: TAG_W] = '0;
      end
    end
  end

endmodule

// File: tb/tb_tagged_register_file.sv
// Directed self-checking bench for tagged_register_file (default and NREAD=4/NREGS=64 instances).
module tb_tagged_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // default instance: XLEN 32, NREGS 32, NREAD 2, TAG_W 4
  logic [9:0]  rs;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [7:0]  rtag;
  logic        iv, cv, fl;
  logic [4:0]  ia, ca;
  logic [3:0]  it, ct;
  logic [31:0] cd;
  logic [5:0]  cnt;

  // wide instance: NREAD 4, NREGS 64
  logic [23:0]  rs2;
  logic [127:0] rd2;
  logic [3:0]   rbusy2;
  logic [15:0]  rtag2;
  logic         iv2, cv2, fl2;
  logic [5:0]   ia2, ca2;
  logic [3:0]   it2, ct2;
  logic [31:0]  cd2;
  logic [6:0]   cnt2;

  tagged_register_file dut (
    .clk_in(clk), .rst_n_in(rst_n), .rs_in(rs), .rd_out(rd), .rbusy_out(rbusy),
    .rtag_out(rtag), .issue_valid_in(iv), .issue_addr_in(ia), .issue_tag_in(it),
    .commit_valid_in(cv), .commit_addr_in(ca), .commit_tag_in(ct),
    .commit_data_in(cd), .flush_in(fl), .busy_count_out(cnt)
  );

  tagged_register_file #(.NREAD(4), .NREGS(64)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .rs_in(rs2), .rd_out(rd2), .rbusy_out(rbusy2),
    .rtag_out(rtag2), .issue_valid_in(iv2), .issue_addr_in(ia2), .issue_tag_in(it2),
    .commit_valid_in(cv2), .commit_addr_in(ca2), .commit_tag_in(ct2),
    .commit_data_in(cd2), .flush_in(fl2), .busy_count_out(cnt2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv = 1'b0; ia = 5'd0; it = 4'd0;
    cv = 1'b0; ca = 5'd0; ct = 4'd0; cd = 32'd0; fl = 1'b0;
    iv2 = 1'b0; ia2 = 6'd0; it2 = 4'd0;
    cv2 = 1'b0; ca2 = 6'd0; ct2 = 4'd0; cd2 = 32'd0; fl2 = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rs = 10'd0; rs2 = 24'd0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    rs = {5'd5, 5'd5};
    #1;
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", rd); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_busy got %0b exp 00", rbusy); end
    checks++; if (rtag !== 8'd0) begin errors++; $display("FAIL reset_tag got %0h exp 0", rtag); end
    checks++; if (cnt !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
    checks++; if (cnt2 !== 7'd0) begin errors++; $display("FAIL reset_count2 got %0d exp 0", cnt2); end
  endtask

  task automatic test_issue_commit();
    iv = 1'b1; ia = 5'd5; it = 4'd3;
    step(); idle();
    rs = {5'd0, 5'd5};
    #1;
    checks++; if (rbusy !== 2'b01) begin errors++; $display("FAIL issue_busy got %0b exp 01", rbusy); end
    checks++; if (rtag[3:0] !== 4'd3) begin errors++; $display("FAIL issue_tag got %0d exp 3", rtag[3:0]); end
    checks++; if (cnt !== 6'd1) begin errors++; $display("FAIL issue_count got %0d exp 1", cnt); end
    cv = 1'b1; ca = 5'd5; ct = 4'd3; cd = 32'hDEADBEEF;
    #1;
    checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data got %0h exp deadbeef", rd[31:0]); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL bypass_busy got %0b exp 0", rbusy[0]); end
    step(); idle();
    #1;
    checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_data got %0h exp deadbeef", rd[31:0]); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL commit_busy got %0b exp 0", rbusy[0]); end
    checks++; if (cnt !== 6'd0) begin errors++; $display("FAIL commit_count got %0d exp 0", cnt); end
  endtask

  task automatic test_stale_commit();
    iv = 1'b1; ia = 5'd7; it = 4'd2;
    step();
    it = 4'd9;
    step(); idle();
    cv = 1'b1; ca = 5'd7; ct = 4'd2; cd = 32'h11;
    rs = {5'd7, 5'd7};
    #1;
    checks++; if (rbusy !== 2'b11) begin errors++; $display("FAIL stale_bypass_busy got %0b exp 11", rbusy); end
    step(); idle();
    #1;
    checks++; if (rd[63:32] !== 32'h11) begin errors++; $display("FAIL stale_data got %0h exp 11", rd[63:32]); end
    checks++; if (rbusy[1] !== 1'b1) begin errors++; $display("FAIL stale_busy got %0b exp 1", rbusy[1]); end
    checks++; if (rtag[7:4] !== 4'd9) begin errors++; $display("FAIL stale_tag got %0d exp 9", rtag[7:4]); end
    checks++; if (cnt !== 6'd1) begin errors++; $display("FAIL stale_count got %0d exp 1", cnt); end
  endtask

  task automatic test_same_cycle();
    iv = 1'b1; ia = 5'd4; it = 4'd1;
    step();
    checks++; if (cnt !== 6'd2) begin errors++; $display("FAIL same_pre_count got %0d exp 2", cnt); end
    it = 4'd6;
    cv = 1'b1; ca = 5'd4; ct = 4'd1; cd = 32'h55;
    step(); idle();
    rs = {5'd0, 5'd4};
    #1;
    checks++; if (rd[31:0] !== 32'h55) begin errors++; $display("FAIL same_data got %0h exp 55", rd[31:0]); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL same_busy got %0b exp 1", rbusy[0]); end
    checks++; if (rtag[3:0] !== 4'd6) begin errors++; $display("FAIL same_tag got %0d exp 6", rtag[3:0]); end
    checks++; if (cnt !== 6'd2) begin errors++; $display("FAIL same_count got %0d exp 2", cnt); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      iv = 1'b1; ia = 5'(r); it = 4'(r);
      step();
    end
    idle();
    checks++; if (cnt !== 6'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", cnt); end
    fl = 1'b1;
    iv = 1'b1; ia = 5'd8; it = 4'd12;
    cv = 1'b1; ca = 5'd2; ct = 4'd0; cd = 32'hCAFE;
    step(); idle();
    rs = {5'd8, 5'd2};
    #1;
    checks++; if (cnt !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", cnt); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL flush_busy got %0b exp 00", rbusy); end
    checks++; if (rd[31:0] !== 32'hCAFE) begin errors++; $display("FAIL flush_commit_data got %0h exp cafe", rd[31:0]); end
    rs = {5'd7, 5'd4};
    #1;
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL flush_busy2 got %0b exp 00", rbusy); end
    checks++; if (rtag !== 8'h96) begin errors++; $display("FAIL flush_tags_kept got %0h exp 96", rtag); end
  endtask

  task automatic test_reg0();
    iv = 1'b1; ia = 5'd9; it = 4'd1;
    iv2 = 1'b1; ia2 = 6'd40; it2 = 4'd7;
    step(); idle();
    iv = 1'b1; ia = 5'd0; it = 4'd5;
    cv = 1'b1; ca = 5'd0; ct = 4'd5; cd = 32'h1234;
    iv2 = 1'b1; ia2 = 6'd0; it2 = 4'd5;
    cv2 = 1'b1; ca2 = 6'd0; ct2 = 4'd5; cd2 = 32'h1234;
    rs = {5'd9, 5'd0};
    rs2 = {6'd63, 6'd0, 6'd40, 6'd0};
    #1;
    checks++; if (rd[31:0] !== 32'd0) begin errors++; $display("FAIL x0_bypass_data got %0h exp 0", rd[31:0]); end
    step(); idle();
    #1;
    checks++; if (rd[31:0] !== 32'd0) begin errors++; $display("FAIL x0_data got %0h exp 0", rd[31:0]); end
    checks++; if (rbusy !== 2'b10) begin errors++; $display("FAIL x0_busy got %0b exp 10", rbusy); end
    checks++; if (rtag !== 8'h10) begin errors++; $display("FAIL x0_tag got %0h exp 10", rtag); end
    checks++; if (cnt !== 6'd1) begin errors++; $display("FAIL x0_count got %0d exp 1", cnt); end
    checks++; if (rd2 !== 128'd0) begin errors++; $display("FAIL w_x0_data got %0h exp 0", rd2); end
    checks++; if (rbusy2 !== 4'b0010) begin errors++; $display("FAIL w_x0_busy got %0b exp 0010", rbusy2); end
    checks++; if (rtag2 !== 16'h0070) begin errors++; $display("FAIL w_x0_tag got %0h exp 0070", rtag2); end
    checks++; if (cnt2 !== 7'd1) begin errors++; $display("FAIL w_x0_count got %0d exp 1", cnt2); end
  endtask

  task automatic test_mid_reset();
    iv = 1'b1; ia = 5'd11; it = 4'd3;
    cv = 1'b1; ca = 5'd2; ct = 4'd0; cd = 32'h77;
    rst_n = 1'b0;
    step(); idle();
    rst_n = 1'b1;
    rs = {5'd11, 5'd2};
    #1;
    checks++; if (cnt !== 6'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", cnt); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL mid_reset_data got %0h exp 0", rd); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL mid_reset_busy got %0b exp 00", rbusy); end
    checks++; if (cnt2 !== 7'd0) begin errors++; $display("FAIL mid_reset_count2 got %0d exp 0", cnt2); end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_reg0();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tagged_register_file.md
# tagged_register_file

Parametrised architectural register file for the out-of-order core. Each register holds a data value, a busy bit and a producer tag (ROB index). Issue marks a destination busy under a new tag. Commit writes the value and clears busy only when the tag still matches. Flush clears all busy state. The block sits between the rename/issue stage, which reads operands and tags, and the commit stage, which retires results into architectural state.

## Interface
- XLEN, 32: register data width.
- NREGS, 32: number of registers, at least 2; register 0 is hardwired zero.
- NREAD, 2: number of read ports, at least 1.
- TAG_W, 4: producer tag width.
- AW, $clog2(NREGS): address width (derived).
- clk_in  input  1  single clock; all state changes on its rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- rs_in  input  NREAD*AW  read addresses, flattened; port k at [k*AW +: AW].
- rd_out  output  NREAD*XLEN  read data, flattened the same way.
- rbusy_out  output  NREAD  per-port busy flag.
- rtag_out  output  NREAD*TAG_W  per-port producer tag.
- issue_valid_in  input  1  mark a destination register busy.
- issue_addr_in  input  AW  destination register of the issuing instruction.
- issue_tag_in  input  TAG_W  ROB tag of the issuing instruction.
- commit_valid_in  input  1  retire a result.
- commit_addr_in  input  AW  register being retired.
- commit_tag_in  input  TAG_W  tag of the retiring instruction.
- commit_data_in  input  XLEN  value being retired.
- flush_in  input  1  mispredict/exception flush.
- busy_count_out  output  $clog2(NREGS+1)  number of registers currently busy.

## Operation
- Per-register state: value[XLEN], busy, tag[TAG_W].
- Reset (rst_n_in low at a rising edge):
  - all values 0, all busy 0, all tags 0, busy_count_out 0.
  - reset overrides every other input in that cycle.
- Register 0:
  - never written, never busy.
  - reads of address 0 return data 0, busy 0, tag 0.
  - issue or commit to address 0 is ignored and does not change the count.
- Issue (issue_valid_in, addr != 0, flush_in low): busy[addr] <= 1, tag[addr] <= issue_tag_in.
- Commit (commit_valid_in, addr != 0):
  - value[addr] <= commit_data_in unconditionally, including during flush.
  - busy[addr] <= 0 only if busy[addr] && tag[addr] == commit_tag_in, and no same-cycle issue to addr.
- Issue and commit to the same register in one cycle:
  - value is written.
  - busy stays 1 and tag takes issue_tag_in (issue wins).
- Flush: all busy bits <= 0 next edge; tags keep their values; issue in the same cycle is ignored.
- Commit-address bypass on reads, per port k, combinational: if commit_valid_in && commit_addr_in == rs[k] && rs[k] != 0:
  - rd = commit_data_in.
  - rbusy = busy && (tag != commit_tag_in).
  - rtag = stored tag.
- No read bypass on issue: a same-cycle issue becomes visible on the next cycle.
- busy_count_out, registered:
  - flush: next value 0.
  - otherwise next = count + (issue sets a non-busy register) - (commit clears busy).
  - Same-register issue+commit with matching tag gives net 0.
  - Never exceeds NREGS-1 and never underflows.

## Timing
- Reads are combinational, zero latency, from current state plus the commit bypass.
- Issue and commit take effect at the next rising edge; a read one cycle later sees the new state.
- busy_count_out updates on the same edge as the busy bits.
- No handshakes or backpressure: every valid input is accepted in its cycle.
- Reset asserted mid-stream: state returns to all-zero on that edge; in-flight issue and commit are dropped.

## Test plan
- Reset, then read x5 on both ports -> data 0, busy 0, tag 0, busy_count_out 0.
- Issue x5 tag 3; next cycle read x5 -> busy 1, tag 3, count 1. Commit x5 tag 3 data 0xDEADBEEF:
  - in the same cycle the read shows data 0xDEADBEEF, busy 0.
  - next cycle: stored value 0xDEADBEEF, busy 0, count 0.
- Stale commit: issue x7 tag 2, then issue x7 tag 9. Commit x7 tag 2 data 0x11 -> value 0x11, busy stays 1, tag 9, count 1.
- Same-cycle issue x4 tag 6 and commit x4 tag 1 (x4 busy with tag 1) data 0x55 -> value 0x55, busy 1, tag 6, count unchanged.
- Issue x1, x2, x3, then flush together with issue x8 -> all busy 0, x8 not busy, count 0. A commit to x2 in the flush cycle still writes its value.
- Issue or commit to x0 with data 0x1234 -> reads of x0 return 0, busy 0, count unchanged. Repeat with NREAD=4, NREGS=64.
